multicycle_control: RTL

Control sequencer for the multi-cycle variant of the MIPS core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux select for the shared ALU, the single unified memory port, the register file and the PC. Memory accesses use a request/ready handshake, so memory latency can vary. The block also keeps a retired-instruction counter and a sticky illegal-instruction flag.

---
 rtl/multicycle_control.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: drives datapath strobes and selects per state,
// handshakes with a variable-latency memory, counts retired instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctl,
    output logic        imm_zero_ext,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic [31:0] retired,
    output logic        illegal
);

    // state  | meaning
    // FETCH  | read instruction at PC, PC += 4 on mem_ready
    // DECODE | dispatch on opcode, branch target into ALUOut
    // MEMADR | effective address for lw/sw
    // MEMRD  | load access, wait for mem_ready
    // MEMWB  | load data to rt
    // MEMWR  | store access, wait for mem_ready
    // RTEXE  | R-type ALU operation
    // RTWB   | ALU result to rd
    // IEXE   | immediate ALU operation
    // IWB    | ALU result to rt
    // BRANCH | compare, conditional PC load from ALUOut
    // JUMP   | PC load from jump target
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEXE  = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_IEXE   = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [3:0]  state_q, state_d;
    logic [31:0] retired_q;
    logic        illegal_q;
    logic        retire, set_illegal;
    logic [3:0]  rt_ctl, imm_ctl;
    logic        fn_legal, imm_zx;

    always_comb begin
        rt_ctl   = ALU_AND;
        fn_legal = 1'b1;
        case (funct)
            FN_ADD:  rt_ctl = ALU_ADD;
            FN_SUB:  rt_ctl = ALU_SUB;
            FN_AND:  rt_ctl = ALU_AND;
            FN_OR:   rt_ctl = ALU_OR;
            FN_SLT:  rt_ctl = ALU_SLT;
            default: fn_legal = 1'b0;
        endcase
    end

    always_comb begin
        imm_ctl = ALU_ADD;
        imm_zx  = 1'b0;
        case (opcode)
            OP_ANDI: begin imm_ctl = ALU_AND; imm_zx = 1'b1; end
            OP_ORI:  begin imm_ctl = ALU_OR;  imm_zx = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_RTYPE:                 state_d = S_RTEXE;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXE;
                    OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_RTEXE: begin
                if (fn_legal) begin
                    state_d = S_RTWB;
                end else begin
                    state_d     = S_FETCH;
                    set_illegal = 1'b1;
                end
            end
            S_IEXE:   state_d = S_IWB;
            S_MEMWB, S_RTWB, S_IWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // Everything reads 0 while rst_n is low so no strobe survives an abort.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_ctl      = 4'b0000;
        imm_zero_ext = 1'b0;
        pc_source    = 2'b00;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctl   = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctl   = ALU_ADD;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctl   = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_RTEXE: begin
                    alu_src_a = 1'b1;
                    alu_ctl   = rt_ctl;
                end
                S_RTWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_IEXE: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = 2'b10;
                    alu_ctl      = imm_ctl;
                    imm_zero_ext = imm_zx;
                end
                S_IWB: begin
                    reg_write    = 1'b1;
                    alu_ctl      = imm_ctl;
                    imm_zero_ext = imm_zx;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctl   = ALU_SUB;
                    pc_source = 2'b01;
                    pc_write  = (opcode == OP_BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + 32'd1;
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule
